// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: synchronises the raw line, times bits from a runtime
// baud divider and delivers words through a valid/ready holding register.
module uart_rx_os #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rx_in,
    input  logic [DIV_WIDTH-1:0] baud_div,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int OSW = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

    state_t               state;
    logic                 rxm, rxs;
    logic [DIV_WIDTH-1:0] div_q, tick_cnt;
    logic [OSW-1:0]       os_cnt, os_last;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 perr_acc, ferr_acc;
    logic                 tick, smp;

    // Start bit is sampled after half a bit; every later sample a full bit apart.
    assign os_last = (state == START) ? OSW'(OVERSAMPLE / 2 - 1) : OSW'(OVERSAMPLE - 1);
    assign tick    = (tick_cnt == div_q);
    assign smp     = tick && (os_cnt == os_last);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rxm <= 1'b1;
            rxs <= 1'b1;
        end else begin
            rxm <= rx_in;
            rxs <= rxm;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            div_q      <= '0;
            tick_cnt   <= '0;
            os_cnt     <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            perr_acc   <= 1'b0;
            ferr_acc   <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    os_cnt   <= '0;
                    bit_cnt  <= '0;
                    if (!rxs) begin
                        state    <= START;
                        div_q    <= baud_div;
                        perr_acc <= 1'b0;
                        ferr_acc <= 1'b0;
                    end
                end
                BRK: begin
                    tick_cnt <= '0;
                    os_cnt   <= '0;
                    if (rxs)
                        state <= IDLE;
                end
                default: begin
                    tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                    if (tick)
                        os_cnt <= smp ? '0 : os_cnt + 1'b1;
                    if (smp) begin
                        case (state)
                            START: state <= rxs ? IDLE : DATA;
                            DATA: begin
                                shift <= {rxs, shift[DATA_BITS-1:1]};
                                if (bit_cnt == 4'(DATA_BITS - 1)) begin
                                    bit_cnt <= '0;
                                    state   <= (PARITY != 0) ? PAR : STOP;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                            PAR: begin
                                // Odd parity expects the XOR to be 1, so invert before flagging.
                                perr_acc <= (^shift) ^ rxs ^ (PARITY == 2);
                                state    <= STOP;
                            end
                            STOP: begin
                                if (bit_cnt == 4'(STOP_BITS - 1)) begin
                                    if (!rx_valid || rx_ready) begin
                                        rx_data    <= shift;
                                        parity_err <= perr_acc;
                                        frame_err  <= ferr_acc | ~rxs;
                                        rx_valid   <= 1'b1;
                                    end else begin
                                        overrun <= 1'b1;
                                    end
                                    state <= rxs ? IDLE : BRK;
                                end else begin
                                    bit_cnt  <= bit_cnt + 1'b1;
                                    ferr_acc <= ferr_acc | ~rxs;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// Directed and randomized checks of uart_rx_os: one 8N1 instance and one 8E1 instance.
module tb_uart_rx_os;
    logic        clk = 1'b0;
    logic        rstn, rx_n, rx_e, rx_ready;
    logic [15:0] baud_div;
    logic [7:0]  data_n, data_e;
    logic        vld_n, vld_e, perr_n, perr_e, ferr_n, ferr_e, ovr_n, ovr_e, busy_n, busy_e;

    int total = 0;
    int bad   = 0;
    int ovr_cnt = 0;
    int vld_cycles = 0;
    logic [9:0] q_n[$];
    logic [9:0] q_e[$];

    always #5 clk = ~clk;

    uart_rx_os #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16), .DIV_WIDTH(16)) dut_n (
        .clk(clk), .rstn(rstn), .rx_in(rx_n), .baud_div(baud_div),
        .rx_data(data_n), .rx_valid(vld_n), .rx_ready(rx_ready),
        .parity_err(perr_n), .frame_err(ferr_n), .overrun(ovr_n), .busy(busy_n));

    uart_rx_os #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(16), .DIV_WIDTH(16)) dut_e (
        .clk(clk), .rstn(rstn), .rx_in(rx_e), .baud_div(baud_div),
        .rx_data(data_e), .rx_valid(vld_e), .rx_ready(rx_ready),
        .parity_err(perr_e), .frame_err(ferr_e), .overrun(ovr_e), .busy(busy_e));

    // Collect every handshake transfer as {frame_err, parity_err, data}.
    always @(negedge clk) begin
        if (vld_n && rx_ready) q_n.push_back({ferr_n, perr_n, data_n});
        if (vld_e && rx_ready) q_e.push_back({ferr_e, perr_e, data_e});
        if (ovr_n) ovr_cnt++;
        if (vld_n) vld_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_word(input bit sel, input string tag, input logic [9:0] exp);
        logic [9:0] w;
        int n;
        n = sel ? q_e.size() : q_n.size();
        check({tag, "_count"}, n, 1);
        if (n > 0) begin
            w = sel ? q_e.pop_front() : q_n.pop_front();
            check(tag, {22'd0, w}, {22'd0, exp});
        end
        if (sel) q_e.delete(); else q_n.delete();
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input bit sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel) rx_e = bits[i]; else rx_n = bits[i];
            repeat (16 * (int'(baud_div) + 1)) @(negedge clk);
        end
    endtask

    function automatic logic [15:0] frame_n(input logic [7:0] d, input logic stop);
        return {7'h7f, stop, d, 1'b0};
    endfunction

    function automatic logic [15:0] frame_e(input logic [7:0] d, input logic p);
        return {5'h1f, 1'b1, p, d, 1'b0};
    endfunction

    // Even parity: total ones over data and parity bit must be even.
    function automatic logic even_err(input logic [7:0] d, input logic p);
        return ((($countones(d) + int'(p)) % 2) != 0);
    endfunction

    initial begin
        int base_o, base_v, low_busy;
        logic [7:0] d;
        logic p;

        rstn = 1'b0; rx_n = 1'b1; rx_e = 1'b1; rx_ready = 1'b1; baud_div = 16'd3;
        settle(4);
        check("rst_valid", vld_n, 0);
        check("rst_data", data_n, 0);
        check("rst_busy", busy_n, 0);
        check("rst_flags", {ovr_n, perr_n, ferr_n, perr_e}, 0);
        rstn = 1'b1;
        settle(10);

        // Basic 8N1 frame
        base_v = vld_cycles;
        send_bits(0, frame_n(8'hA5, 1'b1), 10);
        settle(5);
        check_word(0, "basic_a5", {2'b00, 8'hA5});
        check("basic_valid_1cyc", vld_cycles - base_v, 1);

        // Even parity, correct and wrong parity bit
        send_bits(1, frame_e(8'h37, 1'b1), 11);
        settle(5);
        check_word(1, "par_ok", {1'b0, even_err(8'h37, 1'b1), 8'h37});
        send_bits(1, frame_e(8'h37, 1'b0), 11);
        settle(5);
        check_word(1, "par_bad", {1'b0, even_err(8'h37, 1'b0), 8'h37});

        // Glitch shorter than half a bit
        rx_n = 1'b0; settle(20); rx_n = 1'b1; settle(100);
        check("glitch_no_word", q_n.size(), 0);
        check("glitch_busy", busy_n, 0);
        send_bits(0, frame_n(8'h5A, 1'b1), 10);
        settle(5);
        check_word(0, "after_glitch", {2'b00, 8'h5A});

        // Framing error followed by a long break
        send_bits(0, frame_n(8'h3C, 1'b0), 10);
        low_busy = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!busy_n) low_busy++;
        end
        check("break_busy", low_busy, 0);
        check_word(0, "frame_err", {2'b10, 8'h3C});
        rx_n = 1'b1; settle(10);
        check("break_exit_busy", busy_n, 0);
        send_bits(0, frame_n(8'h11, 1'b1), 10);
        settle(5);
        check_word(0, "after_break", {2'b00, 8'h11});

        // Backpressure with back-to-back frames
        rx_ready = 1'b0;
        base_o = ovr_cnt;
        send_bits(0, frame_n(8'h01, 1'b1), 10);
        send_bits(0, frame_n(8'h02, 1'b1), 10);
        settle(5);
        check("bp_data_held", data_n, 8'h01);
        check("bp_valid_held", vld_n, 1);
        check("bp_overrun", ovr_cnt - base_o, 1);
        rx_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_fall", vld_n, 0);
        check_word(0, "bp_word", {2'b00, 8'h01});

        // Reset in the middle of the data bits, with a word held
        rx_ready = 1'b0;
        send_bits(0, frame_n(8'h7E, 1'b1), 10);
        settle(5);
        check("pre_rst_valid", vld_n, 1);
        send_bits(0, frame_n(8'hC3, 1'b1), 4);
        settle(10);
        check("pre_rst_busy", busy_n, 1);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_valid", vld_n, 0);
        check("mid_rst_data", data_n, 0);
        check("mid_rst_busy", busy_n, 0);
        rx_n = 1'b1;
        settle(5);
        rstn = 1'b1; rx_ready = 1'b1;
        q_n.delete();
        settle(20);
        send_bits(0, frame_n(8'hC3, 1'b1), 10);
        settle(5);
        check_word(0, "after_rst", {2'b00, 8'hC3});

        // Random data, parity bits and baud divisors
        for (int k = 0; k < 6; k++) begin
            baud_div = 16'($urandom_range(0, 3));
            settle(int'($urandom_range(2, 40)));
            d = 8'($urandom);
            send_bits(0, frame_n(d, 1'b1), 10);
            settle(5);
            check_word(0, "rand_n", {2'b00, d});
            d = 8'($urandom);
            p = 1'($urandom);
            send_bits(1, frame_e(d, p), 11);
            settle(5);
            check_word(1, "rand_e", {1'b0, even_err(d, p), d});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised oversampling UART receiver, the successor to the plain shift-in receiver: it finds start bits on the raw serial line itself, times bits from a runtime baud divider, and supports configurable data length, parity and stop bits. It reports framing, parity and overrun errors. It delivers each byte through a valid/ready holding register to the controller-side logic. One instance serves one serial channel.

## Interface
- DATA_BITS, 8: data bits per frame, legal 5..9, sent LSB first.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: stop bits expected, 1 or 2.
- OVERSAMPLE, 16: ticks per bit, even, 4..64.
- DIV_WIDTH, 16: width of baud_div.
- clk  in  1  single clock; all logic on its rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- rx_in  in  1  raw serial line, idle high, asynchronous to clk.
- baud_div  in  DIV_WIDTH  clocks per oversample tick minus 1; sampled only while busy=0.
- rx_data  out  DATA_BITS  received word.
- rx_valid  out  1  rx_data and error flags are valid.
- rx_ready  in  1  consumer accepts the word.
- parity_err  out  1  parity mismatch in the word held; 0 when PARITY=0.
- frame_err  out  1  a stop bit sampled low in the word held.
- overrun  out  1  one-cycle pulse: a completed frame was dropped.
- busy  out  1  a frame is in progress (state other than IDLE).

## Operation
- Input conditioning: rx_in passes through a 2-flop synchroniser, reset value 1; all logic uses the synchronised value rxs.
- Tick generator: counter 0..baud_div, tick when count == baud_div, then wraps to 0. It is held at 0 in IDLE and BREAK. baud_div=0 gives a tick every clock.
- States:
  - IDLE: rxs==0 → START, clear tick counter and sample counter.
  - START: after OVERSAMPLE/2 ticks, sample. rxs==1 is a false start → IDLE with no output. rxs==0 → DATA.
  - DATA: sample every OVERSAMPLE ticks and shift in LSB first. After DATA_BITS samples → PARITY if PARITY≠0, else STOP.
  - PARITY: one sample; compute the mismatch flag. Even: XOR of data and parity bit must be 0. Odd: it must be 1.
  - STOP: STOP_BITS samples. Any low sample sets the frame error. After the last sample, deliver the frame. Go to BREAK if the last stop sample was low, else IDLE.
  - BREAK: wait for rxs==1, then → IDLE. No start detection while in BREAK.
- Delivery: if rx_valid==0, or rx_ready==1 in the same cycle, load rx_data, parity_err and frame_err, and set rx_valid. Otherwise drop the new frame, keep the held word, and pulse overrun.
- Handshake: a transfer happens on a cycle where rx_valid && rx_ready. rx_valid falls the next cycle unless a delivery occurs in that same cycle, in which case it stays 1 with the new word.
- Flags: error flags are only meaningful while rx_valid=1 and change only on delivery.
- baud_div: latched into an internal register on the IDLE→START transition. Changes mid-frame have no effect.
- Reset (asynchronous, any time including mid-frame): state=IDLE, counters=0, synchroniser=1. Outputs: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0. A partial frame is discarded.

## Timing
- Tick period = baud_div+1 clocks. Bit period = OVERSAMPLE×(baud_div+1) clocks.
- The start bit is sampled OVERSAMPLE/2 ticks after the synchronised falling edge. Each later sample comes OVERSAMPLE ticks after the previous one.
- Detection latency: 2 clocks of synchroniser plus 1 clock of IDLE detect.
- rx_valid rises 1 clock after the tick of the last stop sample. overrun pulses in that same cycle.
- busy rises 1 clock after rxs goes low. It falls when IDLE is re-entered, either at delivery or when BREAK exits.
- Back-to-back frames: a start bit that begins right at the nominal end of the stop bit is detected. The receiver re-arms half a bit before the frame's nominal end.

## Test plan
- Basic frame (8N1, OVERSAMPLE=16, baud_div=3, so 64 clocks/bit): send 0xA5, rx_ready=1 → rx_data=0xA5, rx_valid high for 1 cycle, both error flags 0.
- Parity, even (PARITY=1): send 0x37 with parity bit 1 → parity_err=0. Send 0x37 with parity bit 0 → parity_err=1; data still 0x37.
- Noise rejection: 20-clock low glitch (below half a bit = 32 clocks) → no rx_valid, busy returns to 0. A following 0x5A frame is received correctly.
- Framing error and break: stop bit low, then line held low for 500 clocks → frame_err=1 and busy=1 throughout. No second frame until the line goes high. A following 0x11 frame is received correctly.
- Backpressure/overrun: rx_ready=0, send 0x01 then 0x02 → rx_data stays 0x01, overrun pulses once at the end of the 0x02 frame. Raise rx_ready → rx_valid falls the next cycle.
- Reset mid-frame: assert rstn low in the middle of the DATA state → all outputs 0 immediately. After release, a full 0xC3 frame is received correctly.
